// File: rtl/uart_cmd_ctrl.sv
// Frame controller behind the UART receiver: decodes {HEADER, ADDR, DATA, CSUM} write frames,
// issues the register write strobe and an ACK/NAK byte request, and flags checksum and timeout errors.
module uart_cmd_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       frame_err,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_RESP} state_t;

  state_t          state_reg, state_next;
  logic            done_d;
  logic            byte_evt;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      addr_reg, addr_next;
  logic [7:0]      data_reg, data_next;
  logic [7:0]      resp_reg, resp_next;
  logic            reg_wr_en_next, frame_err_next, timeout_err_next, tx_req_next;
  logic [7:0]      reg_addr_next, reg_wdata_next, tx_data_next;
  logic            timed_state;

  // A held-high uart_done is a single byte: only its rising edge counts.
  assign byte_evt    = uart_done & ~done_d;
  assign timed_state = (state_reg == S_ADDR) || (state_reg == S_DATA) || (state_reg == S_CSUM);

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    data_next        = data_reg;
    resp_next        = resp_reg;
    reg_addr_next    = reg_addr;
    reg_wdata_next   = reg_wdata;
    tx_data_next     = tx_data;
    reg_wr_en_next   = 1'b0;
    frame_err_next   = 1'b0;
    timeout_err_next = 1'b0;
    tx_req_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (byte_evt && (uart_data == HEADER)) state_next = S_ADDR;
      end
      S_ADDR, S_DATA, S_CSUM: begin
        if (byte_evt) begin
          if (state_reg == S_ADDR) begin
            addr_next  = uart_data;
            state_next = S_DATA;
          end else if (state_reg == S_DATA) begin
            data_next  = uart_data;
            state_next = S_CSUM;
          end else begin
            if (uart_data == (HEADER ^ addr_reg ^ data_reg)) begin
              reg_addr_next  = addr_reg;
              reg_wdata_next = data_reg;
              reg_wr_en_next = 1'b1;
              resp_next      = ACK_BYTE;
            end else begin
              frame_err_next = 1'b1;
              resp_next      = NAK_BYTE;
            end
            state_next = S_RESP;
          end
        end else if (cnt_reg == CW'(TIMEOUT_CYC - 1)) begin
          timeout_err_next = 1'b1;
          state_next       = S_IDLE;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_data_next = resp_reg;
          tx_req_next  = 1'b1;
          state_next   = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Counter restarts on every byte and on every state entry; idle outside the frame body.
    if (!timed_state || byte_evt || (state_next != state_reg)) cnt_next = '0;
    else                                                       cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= S_IDLE;
      done_d      <= 1'b0;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      resp_reg    <= '0;
      reg_wr_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_reg   <= state_next;
      done_d      <= uart_done;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      resp_reg    <= resp_next;
      reg_wr_en   <= reg_wr_en_next;
      reg_addr    <= reg_addr_next;
      reg_wdata   <= reg_wdata_next;
      tx_req      <= tx_req_next;
      tx_data     <= tx_data_next;
      frame_err   <= frame_err_next;
      timeout_err <= timeout_err_next;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected output events, a monitor pops and
// compares them whenever the DUT pulses reg_wr_en, frame_err, timeout_err or tx_req.
module tb_uart_cmd_ctrl;

  localparam int TOUT = 300;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_done = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       tx_busy = 1'b0;
  logic       reg_wr_en, tx_req, frame_err, timeout_err;
  logic [7:0] reg_addr, reg_wdata, tx_data;

  uart_cmd_ctrl #(.TIMEOUT_CYC(TOUT)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_done   (uart_done),
    .uart_data   (uart_data),
    .reg_wr_en   (reg_wr_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .frame_err   (frame_err),
    .timeout_err (timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {K_WR, K_FERR, K_TOUT, K_TX} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic string kname(kind_t k);
    case (k)
      K_WR:    return "reg_wr_en";
      K_FERR:  return "frame_err";
      K_TOUT:  return "timeout_err";
      default: return "tx_req";
    endcase
  endfunction

  task automatic push(input kind_t k, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input kind_t k, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_%s: got %s a=%02h d=%02h, required no event", kname(k), kname(k), a, d);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind == k && e.a == a && e.d == d) begin
      passes++;
      $display("t=%0t ok %s a=%02h d=%02h", $time, kname(k), a, d);
    end else begin
      $display("FAIL event_%s: got %s a=%02h d=%02h, required %s a=%02h d=%02h",
               kname(e.kind), kname(k), a, d, kname(e.kind), e.a, e.d);
    end
  endtask

  // Monitor: reg_* checked on write and on checksum error (must be unchanged there), tx_data on tx_req.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (reg_wr_en || frame_err) begin
        checks++;
        if (reg_wr_en && frame_err)
          $display("FAIL wr_ferr_exclusive: got reg_wr_en=1 frame_err=1, required not both");
        else
          passes++;
      end
      if (reg_wr_en)   check_evt(K_WR, reg_addr, reg_wdata);
      if (frame_err)   check_evt(K_FERR, reg_addr, reg_wdata);
      if (timeout_err) check_evt(K_TOUT, 8'h00, 8'h00);
      if (tx_req)      check_evt(K_TX, tx_data, 8'h00);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge sys_clk);
    uart_done = 1'b1;
    uart_data = b;
    repeat (hold) @(negedge sys_clk);
    uart_done = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (5) @(negedge sys_clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain_%s: got %0d pending events, required 0", name, exp_q.size());
    else begin
      passes++;
      $display("t=%0t ok drain_%s", $time, name);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [27:0] v;
    v = {reg_wr_en, reg_addr, reg_wdata, tx_req, tx_data, frame_err, timeout_err};
    checks++;
    if (v != 28'h0)
      $display("FAIL %s: got outputs=%07h, required 0000000", name, v);
    else begin
      passes++;
      $display("t=%0t ok %s", $time, name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("reset_state");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: good frame
    push(K_WR, 8'h10, 8'h3C); push(K_TX, 8'h06, 8'h00);
    send_byte(8'hA5, 1); send_byte(8'h10, 1); send_byte(8'h3C, 1); send_byte(8'h89, 1);
    wait_drain("good_frame", 50);

    // 2: bad checksum, registers keep 10/3C
    push(K_FERR, 8'h10, 8'h3C); push(K_TX, 8'h15, 8'h00);
    send_byte(8'hA5, 1); send_byte(8'h10, 1); send_byte(8'h3C, 1); send_byte(8'h88, 1);
    wait_drain("bad_csum", 50);
    checks++;
    if (reg_addr != 8'h10 || reg_wdata != 8'h3C)
      $display("FAIL regs_held: got %02h/%02h, required 10/3C", reg_addr, reg_wdata);
    else begin passes++; $display("t=%0t ok regs_held", $time); end

    // 3: leading junk before header
    push(K_WR, 8'h01, 8'h02); push(K_TX, 8'h06, 8'h00);
    send_byte(8'h00, 1); send_byte(8'hFF, 1);
    send_byte(8'hA5, 1); send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'hA6, 1);
    wait_drain("junk_prefix", 50);

    // 4: timeout after two bytes, then a normal frame
    push(K_TOUT, 8'h00, 8'h00);
    send_byte(8'hA5, 1); send_byte(8'h10, 1);
    repeat (TOUT) @(negedge sys_clk);
    wait_drain("timeout", 20);
    push(K_WR, 8'h20, 8'h55); push(K_TX, 8'h06, 8'h00);
    send_byte(8'hA5, 1); send_byte(8'h20, 1); send_byte(8'h55, 1); send_byte(8'hD0, 1);
    wait_drain("after_timeout", 50);

    // 5: long uart_done pulses, transmitter busy for 100 cycles after the checksum
    push(K_WR, 8'h10, 8'h3C); push(K_TX, 8'h06, 8'h00);
    send_byte(8'hA5, 217); send_byte(8'h10, 217); send_byte(8'h3C, 217);
    @(negedge sys_clk);
    tx_busy   = 1'b1;
    uart_done = 1'b1;
    uart_data = 8'h89;
    repeat (100) @(negedge sys_clk);
    checks++;
    if (exp_q.size() != 1 || exp_q[0].kind != K_TX)
      $display("FAIL tx_wait_busy: got %0d pending, required 1 (tx_req held off)", exp_q.size());
    else begin passes++; $display("t=%0t ok tx_wait_busy", $time); end
    tx_busy = 1'b0;
    repeat (117) @(negedge sys_clk);
    uart_done = 1'b0;
    wait_drain("long_done_busy", 50);

    // 6: reset mid-frame aborts it, then a clean frame
    send_byte(8'hA5, 1); send_byte(8'h10, 1);
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_midframe");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    push(K_WR, 8'h10, 8'h3C); push(K_TX, 8'h06, 8'h00);
    send_byte(8'hA5, 1); send_byte(8'h10, 1); send_byte(8'h3C, 1); send_byte(8'h89, 1);
    wait_drain("after_reset", 50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
